sqr16: RTL and testbench

SQR16 -- requirements
Module: sqr16

---
 rtl/sqr16.sv | 110 +++++++++++
 tb/tb_sqr16.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sqr16.sv
// Sequential unsigned squarer: one shift-add step per clock, fixed N-cycle latency.
// Start is honoured only in IDLE or DONE; y changes only on completion or reset.
module sqr16 #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   x,
  output logic [2*N-1:0] y,
  output logic           rdy,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [2*N-1:0]   mcand_r, mcand_s;
  logic [N-1:0]     mplier_r, mplier_s;
  logic [2*N-1:0]   acc_r, acc_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [2*N-1:0]   y_r, y_s;
  logic             rdy_r, rdy_s;
  logic             busy_r, busy_s;
  logic [2*N-1:0]   acc_sum_s;

  // One shift-add partial product; cannot overflow 2N bits for an N-bit square
  assign acc_sum_s = acc_r + (mplier_r[0] ? mcand_r : {(2*N){1'b0}});

  // State register and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      mcand_r  <= {(2*N){1'b0}};
      mplier_r <= {N{1'b0}};
      acc_r    <= {(2*N){1'b0}};
      cnt_r    <= {CW{1'b0}};
      y_r      <= {(2*N){1'b0}};
      rdy_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      acc_r    <= acc_s;
      cnt_r    <= cnt_s;
      y_r      <= y_s;
      rdy_r    <= rdy_s;
      busy_r   <= busy_s;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_s  = state_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    y_s      = y_r;
    rdy_s    = rdy_r;
    busy_s   = busy_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          mcand_s  = {{N{1'b0}}, x};
          mplier_s = x;
          acc_s    = {(2*N){1'b0}};
          cnt_s    = {CW{1'b0}};
          busy_s   = 1'b1;
          rdy_s    = 1'b0;
          state_s  = RUN;
        end else begin
          state_s  = state_r;
        end
      end
      RUN: begin
        acc_s    = acc_sum_s;
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        cnt_s    = cnt_r + CW'(1);
        if (cnt_r == CW'(N - 1)) begin
          // Last step: publish the sum including this cycle's partial product
          y_s     = acc_sum_s;
          rdy_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        rdy_s   = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign y    = y_r;
  assign rdy  = rdy_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_sqr16.sv
// Self-checking bench for sqr16: directed vector table, corner sequences
// (ignored start, reset mid-run) and a random regression against x*x.
module tb_sqr16;

  localparam int N = 16;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [N-1:0]   x;
  logic [2*N-1:0] y;
  logic           rdy;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*N-1:0] model_y;

  typedef struct {
    logic [N-1:0]   xv;
    logic [2*N-1:0] yv;
  } vec_t;

  vec_t vecs[7];

  sqr16 #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .rdy     (rdy),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one start, follow the run to completion and check everything against x*x
  task automatic run_op(input logic [N-1:0] xv, input int inject_at,
                        input logic [N-1:0] xinj, input bit scramble);
    logic [63:0] exp_y;
    int lat;
    bit done;
    exp_y = 64'(xv) * 64'(xv);
    start = 1'b1;
    x = xv;
    @(posedge clk);
    #1;
    chk("accept_busy", 64'(busy), 64'd1);
    chk("accept_rdy", 64'(rdy), 64'd0);
    chk("accept_y_hold", 64'(y), 64'(model_y));
    lat = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      if (inject_at != 0 && lat == inject_at) begin
        start = 1'b1;
        x = xinj;
      end else begin
        start = 1'b0;
        if (scramble) x = N'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
      if (rdy) begin
        done = 1'b1;
      end else begin
        chk("run_y_hold", 64'(y), 64'(model_y));
        chk("run_busy", 64'(busy), 64'd1);
      end
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'd16);
    chk("result_y", 64'(y), exp_y);
    chk("done_busy", 64'(busy), 64'd0);
    model_y = exp_y[2*N-1:0];
  endtask

  initial begin
    vecs[0] = '{xv: 16'd3,     yv: 32'd9};
    vecs[1] = '{xv: 16'd46341, yv: 32'd2147488281};
    vecs[2] = '{xv: 16'd0,     yv: 32'd0};
    vecs[3] = '{xv: 16'd65535, yv: 32'hFFFE0001};
    vecs[4] = '{xv: 16'd1,     yv: 32'd1};
    vecs[5] = '{xv: 16'd256,   yv: 32'd65536};
    vecs[6] = '{xv: 16'd12,    yv: 32'd144};

    reset_n = 1'b0;
    start   = 1'b0;
    x       = '0;
    model_y = '0;
    #1;
    chk("reset_y", 64'(y), 64'd0);
    chk("reset_rdy", 64'(rdy), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table; vector 1 starts from DONE holding y=9
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].xv, 0, '0, 1'b0);
      chk("table_y", 64'(y), 64'(vecs[i].yv));
      if (i == 0) begin
        for (int c = 0; c < 10; c++) begin
          @(posedge clk);
          #1;
          chk("hold_y", 64'(y), 64'd9);
          chk("hold_rdy", 64'(rdy), 64'd1);
          chk("hold_busy", 64'(busy), 64'd0);
        end
      end
    end

    // Start during RUN must be ignored
    run_op(16'd1000, 5, 16'd7, 1'b0);
    chk("ignored_start_y", 64'(y), 64'd1000000);

    // Reset in the middle of a run
    start = 1'b1;
    x = 16'd500;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_y", 64'(y), 64'd0);
    chk("abort_rdy", 64'(rdy), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    model_y = '0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(16'd12, 0, '0, 1'b0);
    chk("post_reset_y", 64'(y), 64'd144);

    // Random regression, each start issued as soon as rdy rises; x wiggles mid-run
    for (int r = 0; r < 1000; r++) begin
      run_op(N'($urandom), 0, '0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
